// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: conversion FSM states,
// active-low segment patterns and the default refresh divider.
package seven_seg_pkg;

  localparam int REFRESH_DIV_DEFAULT = 100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } conv_state_t;

  localparam logic [13:0] MAX_DISPLAY = 14'd9999;

  // Patterns are {g,f,e,d,c,b,a}, a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: loads on a change of value, shifts 14
// times, then latches the four BCD digits for display.
module bin_to_bcd
  import seven_seg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value,
  output logic [15:0] bcd_out,
  output logic        busy
);

  conv_state_t state;
  conv_state_t state_next;

  logic [13:0] last_value;
  logic [13:0] shreg;
  logic [15:0] acc;
  logic [15:0] acc_adj;
  logic [3:0]  bit_cnt;
  logic        start;

  // A change that arrives mid-conversion is picked up here once back in IDLE.
  assign start = (value != last_value);
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_CONV;
      ST_CONV:  if (bit_cnt == 4'd13) state_next = ST_LATCH;
      ST_LATCH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) begin
        acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_value <= '0;
      shreg      <= '0;
      acc        <= '0;
      bit_cnt    <= '0;
      bcd_out    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            last_value <= value;
            shreg      <= (value > MAX_DISPLAY) ? MAX_DISPLAY : value;
            acc        <= '0;
            bit_cnt    <= '0;
          end
        end
        ST_CONV: begin
          {acc, shreg} <= {acc_adj[14:0], shreg, 1'b0};
          bit_cnt      <= bit_cnt + 4'd1;
        end
        ST_LATCH: begin
          bcd_out <= acc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed seven-segment driver: converts value to BCD and
// scans the digits with leading-zero blanking.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        busy
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  logic [15:0]   digits;
  logic [CW-1:0] div_cnt;
  logic [1:0]    sel;
  logic [3:0]    cur_digit;
  logic [3:0]    lz;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  bin_to_bcd u_conv (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .bcd_out (digits),
    .busy    (busy)
  );

  assign dp = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      sel     <= 2'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      sel     <= sel + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // lz[k] is set when digit k and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    lz    = 4'b0000;
    lz[3] = (digits[15:12] == 4'd0);
    lz[2] = lz[3] && (digits[11:8] == 4'd0);
    lz[1] = lz[2] && (digits[7:4] == 4'd0);
  end

  always_comb begin
    cur_digit = digits[3:0];
    case (sel)
      2'd1:    cur_digit = digits[7:4];
      2'd2:    cur_digit = digits[11:8];
      2'd3:    cur_digit = digits[15:12];
      default: cur_digit = digits[3:0];
    endcase
  end

  always_comb begin
    an_next  = ~(4'b0001 << sel);
    seg_next = seg_pattern(cur_digit);
    if ((BLANK_LZ != 0) && lz[sel]) begin
      seg_next = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: directed scenarios plus
// random values, compared every cycle against a decimal-arithmetic model.
module tb_seven_segment_scanner;

  localparam int DIV = 4;
  localparam int CONV_LATENCY = 15;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [13:0] value = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        busy;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .REFRESH_DIV (DIV),
    .BLANK_LZ    (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .seg   (seg),
    .an    (an),
    .dp    (dp),
    .busy  (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [13:0] exp_q [$];
  int          m_rem = 0;
  int          m_last = 0;
  int          m_shown = 0;
  int          m_sel = 0;
  int          m_div = 0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [3:0]  exp_an = 4'hF;

  function automatic logic [6:0] disp(input int n, input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && n < p) return 7'h7F;
    return pat[(n / p) % 10];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rem = 0;
      m_last = 0;
      m_shown = 0;
      m_sel = 0;
      m_div = 0;
      exp_q.delete();
      exp_seg = 7'h7F;
      exp_an = 4'hF;
    end else begin
      exp_an = 4'hF ^ (4'h1 << m_sel);
      exp_seg = disp(m_shown, m_sel);
      if (m_div == DIV - 1) begin
        m_div = 0;
        m_sel = (m_sel + 1) % 4;
      end else begin
        m_div++;
      end
      if (m_rem == 0) begin
        if (int'(value) != m_last) begin
          m_last = int'(value);
          exp_q.push_back((value > 14'd9999) ? 14'd9999 : value);
          m_rem = CONV_LATENCY;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_shown = int'(exp_q.pop_front());
      end
    end
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin
    check("an", an, exp_an);
    check("seg", seg, exp_seg);
    check("busy", busy, (m_rem != 0));
    check("dp", dp, 1'b1);
  end

  // driver tasks
  task automatic drive(input logic [13:0] v, input int cycles);
    @(negedge clk);
    value = v;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_busy", busy, 1'b0);
    check("rst_dp", dp, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    repeat (24) @(negedge clk);

    drive(14'd1234, 40);
    drive(14'd12000, 40);
    drive(14'd7, 5);
    drive(14'd305, 50);
    drive(14'd0, 30);

    // reset lands after 7 shifts of the 0 -> 8000 conversion
    drive(14'd8000, 8);
    check("busy_mid_conv", busy, 1'b1);
    async_reset_pulse();
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [13:0] v;
      v = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) == 0) v = 14'($urandom_range(0, 120));
      drive(v, int'($urandom_range(1, 30)));
    end
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz).
REQ-002 SHALL have parameter BLANK_LZ, default 1, 1 = blank leading zeros.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port value  input  14  unsigned binary number from the digit accumulator stage.
REQ-006 SHALL have port seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-007 SHALL have port an  output  4  digit anodes, active-low, an[0] = ones digit, an[3] = thousands digit.
REQ-008 SHALL have port dp  output  1  decimal point, active-low, held 1 (off).
REQ-009 SHALL have port busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-010 SHALL run the conversion FSM with states IDLE, CONV and LATCH.
REQ-011 In IDLE, SHALL load on an edge where value != last_value: last_value <= value; shift register <= min(value, 9999); BCD accumulator <= 0; bit counter <= 0; state <= CONV.
REQ-012 SHALL saturate inputs 10000..16383 to 9999 before conversion.
REQ-013 In CONV, SHALL on each edge add 3 to every BCD nibble >= 5, then shift {bcd, shift register} left by one (double dabble).
REQ-014 SHALL leave CONV for LATCH after exactly 14 shifts (counter == 13).
REQ-015 In LATCH, SHALL copy the accumulator into the four digit registers d0..d3 and return to IDLE.
REQ-016 SHALL update the digit registers on the 15th rising edge after the load edge (14 shifts + 1 latch).
REQ-017 SHALL drive busy = 1 in CONV and LATCH, 0 in IDLE.
REQ-018 SHALL ignore changes to value during CONV/LATCH; the IDLE comparison against last_value catches them, so a conversion starts on the first IDLE edge after LATCH.
REQ-019 SHALL keep displaying the previous digit registers during a conversion.
REQ-020 SHALL count a refresh counter 0..REFRESH_DIV-1 and wrap it to 0; on wrap the 2-bit digit select SHALL increment modulo 4 (3 -> 0).
REQ-021 SHALL register an and seg one edge after a select or digit-register change.
REQ-022 SHALL drive an as one-hot-low for the selected digit, with seg = pattern of d[select].
REQ-023 With BLANK_LZ = 1, SHALL blank digit k (seg = 7'h7F, anode still scanned) when dk and every higher digit are 0.
REQ-024 SHALL never blank digit 0, so value 0 displays "0".
REQ-025 SHALL use active-low segment patterns for 0..9: 40,79,24,30,19,12,02,78,00,10 (hex).
REQ-026 SHALL run scanning continuously and independently of the conversion FSM.

Reset
REQ-027 While reset = 0, SHALL force seg = 7'h7F, an = 4'hF, dp = 1, busy = 0, state IDLE, and set d0..d3, last_value, counters, select and accumulator to 0.
REQ-028 On a reset assertion mid-conversion, SHALL abort immediately, leave no digit update, and start a conversion after release if value != 0.
REQ-029 On the first edge after release with value = 0, SHALL start no conversion and display "0" on an[0].

Structure
REQ-030 SHALL place the FSM state encodings, the segment pattern constants (0..9, blank) and the REFRESH_DIV default in a shared package, seven_seg_pkg.
REQ-031 SHALL implement the load/shift/latch datapath and busy in one sub-module, bin_to_bcd; the top level holds the refresh counter, blanking and anode/segment muxing.

Verification
REQ-032 SHALL cover: release reset with value = 0 -> busy stays 0; an cycles E,D,B,7; seg = 40 on an = E, else 7F.
REQ-033 SHALL cover: value 0 -> 1234 -> busy high for 15 cycles; digits 4,3,2,1 update on the 15th edge after load; seg 19,30,24,79 on an E,D,B,7.
REQ-034 SHALL cover: value 12000 -> displays 9999 (seg 10 on all four anodes).
REQ-035 SHALL cover: value 7 -> 305 during CONV, with 305 held until LATCH -> 7 shown; a second conversion starts on the next IDLE edge; final display "305" with the thousands digit blanked.
REQ-036 SHALL cover: reset asserted at shift 7 of conversion 0 -> 8000 -> all outputs take reset values asynchronously; after release, conversion restarts and shows 8000.
REQ-037 SHALL cover: REFRESH_DIV = 4 -> select advances every 4 cycles and wraps from 3 -> 0.
